bomb_scheduler: RTL

BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

---
 rtl/bomb_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/bomb_scheduler.sv
// Shared bomb-slot scheduler: two players drop timed bombs into a fixed pool of slots,
// each slot running IDLE -> FUSE -> BLAST on a tick time base.
module bomb_scheduler #(
  parameter int unsigned NSLOTS         = 4,
  parameter int unsigned MAX_PER_PLAYER = 2,
  parameter int unsigned FUSE_TICKS     = 3,
  parameter int unsigned BLAST_TICKS    = 2,
  parameter int unsigned CW             = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 a_req,
  input  logic [CW-1:0]        a_x,
  input  logic [CW-1:0]        a_y,
  input  logic                 b_req,
  input  logic [CW-1:0]        b_x,
  input  logic [CW-1:0]        b_y,
  output logic                 a_ack,
  output logic                 a_nack,
  output logic                 b_ack,
  output logic                 b_nack,
  output logic [NSLOTS-1:0]    slot_active,
  output logic [NSLOTS-1:0]    slot_blast,
  output logic [NSLOTS-1:0]    slot_owner,
  output logic [NSLOTS*CW-1:0] slot_x,
  output logic [NSLOTS*CW-1:0] slot_y,
  output logic [NSLOTS-1:0]    explode
);

  localparam int unsigned TMAX = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, FUSE, BLAST} slot_state_t;

  slot_state_t       st  [NSLOTS];
  logic [TW-1:0]     cnt [NSLOTS];
  logic              prio;
  logic [NSLOTS-1:0] busy;
  logic [NSLOTS-1:0] free0, free1, alloc0, alloc1, a_alloc, b_alloc;
  logic              ok0, ok1, a_ok, b_ok;
  logic              rq0, rq1;
  logic [CW-1:0]     x0, y0, x1, y1;

  function automatic logic [NSLOTS-1:0] pick(input logic [NSLOTS-1:0] used);
    logic [NSLOTS-1:0] r;
    logic              found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (!used[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic int unsigned owned(input logic [NSLOTS-1:0] used,
                                        input logic [NSLOTS-1:0] own,
                                        input logic              who);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NSLOTS; i++)
      if (used[i] && own[i] == who) n = n + 1;
    return n;
  endfunction

  function automatic logic hit(input logic [NSLOTS-1:0]    used,
                               input logic [NSLOTS*CW-1:0] xs,
                               input logic [NSLOTS*CW-1:0] ys,
                               input logic [CW-1:0]        x,
                               input logic [CW-1:0]        y);
    logic h;
    h = 1'b0;
    for (int i = 0; i < NSLOTS; i++)
      if (used[i] && xs[i*CW +: CW] == x && ys[i*CW +: CW] == y) h = 1'b1;
    return h;
  endfunction

  always_comb begin
    for (int i = 0; i < NSLOTS; i++) begin
      busy[i]        = (st[i] != IDLE);
      slot_active[i] = (st[i] != IDLE);
      slot_blast[i]  = (st[i] == BLAST);
    end
  end

  // Priority player evaluated on registered state, the other against the post-allocation view.
  always_comb begin
    rq0 = prio ? b_req : a_req;
    x0  = prio ? b_x   : a_x;
    y0  = prio ? b_y   : a_y;
    rq1 = prio ? a_req : b_req;
    x1  = prio ? a_x   : b_x;
    y1  = prio ? a_y   : b_y;

    free0  = pick(busy);
    ok0    = rq0 && (free0 != '0)
             && (owned(busy, slot_owner, prio) < MAX_PER_PLAYER)
             && !hit(busy, slot_x, slot_y, x0, y0);
    alloc0 = ok0 ? free0 : '0;

    free1  = pick(busy | alloc0);
    ok1    = rq1 && (free1 != '0)
             && (owned(busy, slot_owner, ~prio) < MAX_PER_PLAYER)
             && !hit(busy, slot_x, slot_y, x1, y1)
             && !(ok0 && x0 == x1 && y0 == y1);
    alloc1 = ok1 ? free1 : '0;

    a_ok    = prio ? ok1    : ok0;
    b_ok    = prio ? ok0    : ok1;
    a_alloc = prio ? alloc1 : alloc0;
    b_alloc = prio ? alloc0 : alloc1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSLOTS; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
      slot_owner <= '0;
      slot_x     <= '0;
      slot_y     <= '0;
      explode    <= '0;
      a_ack      <= 1'b0;
      a_nack     <= 1'b0;
      b_ack      <= 1'b0;
      b_nack     <= 1'b0;
      prio       <= 1'b0;
    end else begin
      a_ack  <= a_req && a_ok;
      a_nack <= a_req && !a_ok;
      b_ack  <= b_req && b_ok;
      b_nack <= b_req && !b_ok;
      if (a_req && b_req) prio <= ~prio;

      for (int i = 0; i < NSLOTS; i++) begin
        explode[i] <= 1'b0;
        // A freshly allocated slot skips any tick in the same cycle.
        if (a_alloc[i] || b_alloc[i]) begin
          st[i]              <= FUSE;
          cnt[i]             <= TW'(FUSE_TICKS);
          slot_owner[i]      <= b_alloc[i];
          slot_x[i*CW +: CW] <= b_alloc[i] ? b_x : a_x;
          slot_y[i*CW +: CW] <= b_alloc[i] ? b_y : a_y;
        end else if (tick) begin
          case (st[i])
            FUSE: begin
              if (cnt[i] == TW'(1)) begin
                st[i]      <= BLAST;
                cnt[i]     <= TW'(BLAST_TICKS);
                explode[i] <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] - TW'(1);
              end
            end
            BLAST: begin
              if (cnt[i] == TW'(1)) begin
                st[i]  <= IDLE;
                cnt[i] <= '0;
              end else begin
                cnt[i] <= cnt[i] - TW'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
